// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice per clock, carry chained in a register.
// Define NIBBLE_SERIAL_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;

  logic [3:0] a_nib, b_nib, g, p, s;
  logic       c1, c2, c3, c4, last;

  // Nibble select plus a single lookahead slice: the only combinational path per cycle.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (k_q == KW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    g  = a_nib & b_nib;
    p  = a_nib ^ b_nib;
    c1 = g[0] | (p[0] & carry_q);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & carry_q);
    s  = p ^ {c3, c2, c1, carry_q};
    last = (k_q == KW'(N - 1));
  end

`ifdef NIBBLE_SERIAL_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      k_q       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= cin;
            sum      <= '0;
            cout     <= 1'b0;
            k_q      <= '0;
            in_ready <= 1'b0;
            state_q  <= StRun;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
          end
        end
        StRun: begin
          for (int i = 0; i < int'(N); i++) begin
            if (k_q == KW'(i)) sum[4*i +: 4] <= s;
          end
          carry_q <= c4;
          k_q     <= k_q + KW'(1);
          if (last) begin
            cout      <= c4;
            out_valid <= 1'b1;
            state_q   <= StDone;
`ifdef NIBBLE_SERIAL_OVF_EN
            // Carry into the sign bit differs from carry out of it.
            ovf_q     <= c3 ^ c4;
`endif
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that splits WIDTH-bit operands into 4-bit nibbles and adds one nibble per clock through an internal 4-bit carry-lookahead slice. Carry is chained across cycles in a register. The block sits on the adder datapath between an operand producer (valid/ready upstream) and a result consumer (valid/ready downstream). It is the area-cheap alternative when a full-width lookahead adder is not needed.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibbles
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand pair + cin presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A (unsigned; two's complement under overflow option)
- b  in  WIDTH  operand B
- cin  in  1  carry into nibble 0
- out_valid  out  1  sum/cout valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  A + B + cin, modulo 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow; present only with NIBBLE_SERIAL_OVF_EN

## Operation
- States: IDLE, RUN, DONE; reset state IDLE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b; load carry register with cin; clear sum and cout; nibble index k=0; go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - Compute {c, s} = a[4k+3:4k] + b[4k+3:4k] + carry_reg using G=a&b, P=a^b and lookahead carries c1..c4 with carry-in. Bit 0 carry must include cin (c1 = G0 | P0&cin).
  - Write s into sum[4k+3:4k]; carry_reg ← c4; k ← k+1.
  - After nibble N-1: cout ← c4; go to DONE.
- DONE: out_valid=1; sum, cout (and ovf) held stable until out_valid&&out_ready; then go to IDLE.
- No accept in the cycle a result handshakes; in_ready rises the next cycle.
- in_valid while not in IDLE: ignored; upstream must hold data until in_ready.
- out_ready while not in DONE: ignored.
- Synchronous reset while in RUN/DONE: operation abandoned, no out_valid, state IDLE.
- Reset values (after clk edge with rst_n=0): in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, k=0, carry_reg=0.
- Latched operands are unaffected by input changes after acceptance.

## Timing
- Accept at edge T → RUN during cycles T+1..T+N → out_valid=1 from cycle T+N+1.
- WIDTH=16: 4 RUN cycles; result visible 5 cycles after accept.
- With out_ready held high: handshake at T+N+1, IDLE at T+N+2. Peak throughput is one add per N+2 cycles.
- Combinational path per cycle is limited to one 4-bit lookahead slice plus a nibble mux. No ripple across nibbles within a cycle.
- in_ready and out_valid are registered state decodes. Neither combinationally depends on in_valid or out_ready.

## Configuration
- NIBBLE_SERIAL_OVF_EN defined:
  - ovf port exists.
  - During the final nibble, ovf ← carry into bit WIDTH-1 XOR c4.
  - ovf is cleared on accept, held in DONE, and resets to 0.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 two cycles → in_ready=1, out_valid=0, sum=0x0000, cout=0.
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → out_valid exactly 5 cycles after accept, sum=0x0000, cout=1 (full carry chain across all 4 nibbles).
- a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0. Then back-to-back ops with out_ready=1 → in_ready low for cycles T+1..T+5 and high at T+6.
- Backpressure: result with out_ready=0 for 7 cycles, with a/b/in_valid toggling → out_valid stays 1, sum/cout constant, no new accept. Raise out_ready → one handshake, then IDLE.
- Reset mid-op: accept a=0x00FF, b=0x0001, then assert rst_n=0 during RUN cycle 2 → no out_valid ever for that op; all outputs return to reset values.
- With NIBBLE_SERIAL_OVF_EN: 0x7FFF+0x0001 → sum=0x8000, ovf=1, cout=0. 0xFFFF+0x0001 → ovf=0, cout=1. 0x8000+0x8000 → sum=0x0000, ovf=1, cout=1.
